// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ROB tag width default, CDB source indices, CDB entry layout.
package cpu_pkg;

    localparam int DEFAULT_ROB_WIDTH = 4;
    localparam int VAL_WIDTH         = 32;

    // CDB source indices (producer slot on the arbiter)
    localparam int SRC_ALU = 0;
    localparam int SRC_LSB = 1;
    localparam int SRC_BR  = 2;

    // CDB entry layout: value in the upper bits, ROB destination tag in the lower bits
    typedef struct packed {
        logic [VAL_WIDTH-1:0]         val;
        logic [DEFAULT_ROB_WIDTH-1:0] dest;
    } cdbEntry_t;

    function automatic int entryWidth(input int robWidth);
        return VAL_WIDTH + robWidth;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-producer FIFO feeding the CDB arbiter. Count register drives full/empty;
// flush empties it and beats any same-cycle push or pop.
module cdb_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = entryWidth(DEFAULT_ROB_WIDTH),
    parameter int DEPTH = 2
) (
    input  logic             clockIn,
    input  logic             resetIn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    // A pop in the same cycle does not make room for a push into a full FIFO,
    // so push qualification looks only at the registered count.
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push & ~full & ~flush;
    assign doPop  = pop & ~empty & ~flush;
    assign dout   = mem[rdPtr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clockIn) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per producer, round-robin pop of one entry per
// cycle, registered broadcast. No bypass: a pushed entry is visible one edge later at best.
module cdb_arbiter
    import cpu_pkg::*;
#(
    parameter int ROB_WIDTH  = DEFAULT_ROB_WIDTH,
    parameter int NUM_REQ    = 3,
    parameter int FIFO_DEPTH = 2,
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clockIn,
    input  logic                         resetIn,
    input  logic                         readyIn,
    input  logic                         flushIn,
    input  logic [NUM_REQ-1:0]           reqFlag,
    input  logic [NUM_REQ*32-1:0]        reqVal,
    input  logic [NUM_REQ*ROB_WIDTH-1:0] reqDest,
    output logic [NUM_REQ-1:0]           reqFull,
    output logic                         cdbFlag,
    output logic [31:0]                  cdbVal,
    output logic [ROB_WIDTH-1:0]         cdbDest,
    output logic [SRC_W-1:0]             cdbSrc
);

    localparam int ENTRY_W = VAL_WIDTH + ROB_WIDTH;

    logic [NUM_REQ-1:0] fifoEmpty;
    logic [NUM_REQ-1:0] fifoFull;
    logic [ENTRY_W-1:0] fifoHead [NUM_REQ];
    logic [SRC_W-1:0]   rrPtr;
    logic [SRC_W-1:0]   winIdx;
    logic               anyValid;
    logic [ENTRY_W-1:0] winHead;

    assign reqFull = fifoFull;
    assign winHead = fifoHead[winIdx];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gFifo
        logic pushEn;
        logic popEn;

        assign pushEn = readyIn & reqFlag[g];
        assign popEn  = readyIn & anyValid & (winIdx == SRC_W'(g));

        cdb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) uFifo (
            .clockIn (clockIn),
            .resetIn (resetIn),
            .push    (pushEn),
            .pop     (popEn),
            .flush   (flushIn),
            .din     ({reqVal[32*g +: 32], reqDest[ROB_WIDTH*g +: ROB_WIDTH]}),
            .dout    (fifoHead[g]),
            .empty   (fifoEmpty[g]),
            .full    (fifoFull[g])
        );
    end

    // Round-robin search starting one past the last winner; first non-empty FIFO wins.
    always_comb begin
        int cand;
        anyValid = 1'b0;
        winIdx   = '0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rrPtr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!anyValid && !fifoEmpty[SRC_W'(cand)]) begin
                anyValid = 1'b1;
                winIdx   = SRC_W'(cand);
            end
        end
    end

    // Registered broadcast and priority pointer; data holds while no entry is broadcast.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            rrPtr   <= SRC_W'(NUM_REQ - 1);
            cdbFlag <= 1'b0;
            cdbVal  <= '0;
            cdbDest <= '0;
            cdbSrc  <= '0;
        end else if (flushIn) begin
            cdbFlag <= 1'b0;
        end else if (readyIn) begin
            cdbFlag <= anyValid;
            if (anyValid) begin
                rrPtr   <= winIdx;
                cdbVal  <= winHead[ENTRY_W-1 -: 32];
                cdbDest <= winHead[ROB_WIDTH-1:0];
                cdbSrc  <= winIdx;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: constant-vector table, hand sequences for corner cases,
// and randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;
    import cpu_pkg::*;

    localparam int RW = 4;
    localparam int NR = 3;
    localparam int FD = 2;

    logic           clockIn = 1'b0;
    logic           resetIn;
    logic           readyIn;
    logic           flushIn;
    logic [NR-1:0]  reqFlag;
    logic [NR*32-1:0] reqVal;
    logic [NR*RW-1:0] reqDest;
    logic [NR-1:0]  reqFull;
    logic           cdbFlag;
    logic [31:0]    cdbVal;
    logic [RW-1:0]  cdbDest;
    logic [1:0]     cdbSrc;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.ROB_WIDTH(RW), .NUM_REQ(NR), .FIFO_DEPTH(FD)) dut (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .readyIn (readyIn),
        .flushIn (flushIn),
        .reqFlag (reqFlag),
        .reqVal  (reqVal),
        .reqDest (reqDest),
        .reqFull (reqFull),
        .cdbFlag (cdbFlag),
        .cdbVal  (cdbVal),
        .cdbDest (cdbDest),
        .cdbSrc  (cdbSrc)
    );

    always #5 clockIn = ~clockIn;

    // reference model: one queue per producer plus the broadcast register
    logic [35:0] mq [NR][$];
    int          mPtr;
    logic        mFlag;
    logic [31:0] mVal;
    logic [3:0]  mDest;
    logic [1:0]  mSrc;

    task automatic modelReset();
        for (int i = 0; i < NR; i++) mq[i].delete();
        mPtr = NR - 1;
        mFlag = 1'b0; mVal = '0; mDest = '0; mSrc = '0;
    endtask

    task automatic modelStep();
        int win;
        bit [NR-1:0] wasFull;
        logic [35:0] e;
        if (flushIn) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
            mFlag = 1'b0;
        end else if (readyIn) begin
            win = -1;
            for (int i = 0; i < NR; i++) wasFull[i] = (mq[i].size() == FD);
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (mPtr + k) % NR;
                if (win < 0 && mq[c].size() > 0) win = c;
            end
            if (win >= 0) begin
                e = mq[win].pop_front();
                mFlag = 1'b1;
                mVal  = e[35:4];
                mDest = e[3:0];
                mSrc  = 2'(win);
                mPtr  = win;
            end else begin
                mFlag = 1'b0;
            end
            for (int i = 0; i < NR; i++)
                if (reqFlag[i] && !wasFull[i])
                    mq[i].push_back({reqVal[32*i +: 32], reqDest[RW*i +: RW]});
        end
    endtask

    function automatic logic [NR-1:0] modelFull();
        logic [NR-1:0] f;
        for (int i = 0; i < NR; i++) f[i] = (mq[i].size() == FD);
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // one clock: protocol check, edge, model update, compare after the edge
    task automatic tick();
        chk("push_while_full", 32'(reqFlag & reqFull & {NR{readyIn & ~flushIn}}), 32'd0);
        @(posedge clockIn);
        modelStep();
        #1;
        chk("m_flag", 32'(cdbFlag), 32'(mFlag));
        chk("m_val",  cdbVal, mVal);
        chk("m_dest", 32'(cdbDest), 32'(mDest));
        chk("m_src",  32'(cdbSrc), 32'(mSrc));
        chk("m_full", 32'(reqFull), 32'(modelFull()));
    endtask

    task automatic idleInputs();
        readyIn = 1'b1; flushIn = 1'b0; reqFlag = '0; reqVal = '0; reqDest = '0;
    endtask

    task automatic applyReset();
        idleInputs();
        resetIn = 1'b0;
        modelReset();
        #3;
        chk("rst_flag", 32'(cdbFlag), 32'd0);
        chk("rst_full", 32'(reqFull), 32'd0);
        chk("rst_data", {cdbVal[27:0], cdbDest}, 32'd0);
        chk("rst_src",  32'(cdbSrc), 32'd0);
        @(negedge clockIn);
        resetIn = 1'b1;
    endtask

    // leaves FIFO0 full (2 entries), FIFO2 with 1 entry, ptr at 1
    task automatic fillZero();
        applyReset();
        reqFlag = 3'b111;
        reqVal  = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
        reqDest = {4'd3, 4'd2, 4'd1};
        tick();
        reqFlag = 3'b001; reqVal[31:0] = 32'hA000_0001; reqDest[3:0] = 4'd4;
        tick();
        reqVal[31:0] = 32'hA000_0002; reqDest[3:0] = 4'd6;
        tick();
        reqFlag = '0;
        chk("fill_full0", 32'(reqFull[0]), 32'd1);
    endtask

    typedef struct {
        bit          doReset;
        logic [2:0]  flag;
        logic [31:0] v0, v1, v2;
        logic [3:0]  d0, d1, d2;
        logic        eFlag;
        logic [31:0] eVal;
        logic [3:0]  eDest;
        logic [1:0]  eSrc;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cnt0, cnt2, nBc, lastSrc;

        resetIn = 1'b0;
        idleInputs();

        // single push latency, then 3-way contention from reset
        tbl[0] = '{1, 3'b010, 0, 32'hDEADBEEF, 0, 0, 5, 0, 0, 32'h0, 0, 0};
        tbl[1] = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 5, 1};
        tbl[2] = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 5, 1};
        tbl[3] = '{1, 3'b111, 32'h100, 32'h101, 32'h102, 1, 2, 3, 0, 32'h0, 0, 0};
        tbl[4] = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h100, 1, 0};
        tbl[5] = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h101, 2, 1};
        tbl[6] = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h102, 3, 2};
        tbl[7] = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h102, 3, 2};

        for (int r = 0; r < 8; r++) begin
            if (tbl[r].doReset) applyReset();
            reqFlag = tbl[r].flag;
            reqVal  = {tbl[r].v2, tbl[r].v1, tbl[r].v0};
            reqDest = {tbl[r].d2, tbl[r].d1, tbl[r].d0};
            tick();
            chk($sformatf("tbl%0d_flag", r), 32'(cdbFlag), 32'(tbl[r].eFlag));
            chk($sformatf("tbl%0d_val", r),  cdbVal, tbl[r].eVal);
            chk($sformatf("tbl%0d_dest", r), 32'(cdbDest), 32'(tbl[r].eDest));
            chk($sformatf("tbl%0d_src", r),  32'(cdbSrc), 32'(tbl[r].eSrc));
        end

        // reset mid-traffic: outputs clear without a clock edge
        fillZero();
        resetIn = 1'b0;
        #2;
        chk("midrst_flag", 32'(cdbFlag), 32'd0);
        chk("midrst_full", 32'(reqFull), 32'd0);
        modelReset();
        @(negedge clockIn);
        resetIn = 1'b1;

        // full/stall: pushes blocked while not ready, exactly 2 producer-0 entries drain
        fillZero();
        readyIn = 1'b0;
        reqFlag = 3'b001; reqVal[31:0] = 32'hA000_00FF;
        tick();
        tick();
        chk("stall_full0", 32'(reqFull[0]), 32'd1);
        chk("stall_hold_src", 32'(cdbSrc), 32'd1);
        readyIn = 1'b1; reqFlag = '0;
        cnt0 = 0; nBc = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (cdbFlag) begin
                nBc++;
                if (cdbSrc == 2'd0) cnt0++;
            end
        end
        chk("stall_src0_count", 32'(cnt0), 32'd2);
        chk("stall_bcast_count", 32'(nBc), 32'd3);

        // fairness: producers 0 and 2 push whenever not full
        applyReset();
        cnt0 = 0; cnt2 = 0; lastSrc = -1;
        for (int c = 0; c < 12; c++) begin
            reqFlag = {~modelFull()[2], 1'b0, ~modelFull()[0]};
            reqVal  = {32'h2000_0000 + 32'(c), 32'h0, 32'h0000_1000 + 32'(c)};
            reqDest = {4'(c), 4'd0, 4'(c + 8)};
            tick();
            if (cdbFlag) begin
                if (lastSrc >= 0) chk("fair_alternate", 32'(cdbSrc != 2'(lastSrc)), 32'd1);
                lastSrc = int'(cdbSrc);
                if (cdbSrc == 2'd0) cnt0++;
                if (cdbSrc == 2'd2) cnt2++;
            end
        end
        reqFlag = '0;
        chk("fair_cnt0", 32'(cnt0 >= 5), 32'd1);
        chk("fair_cnt2", 32'(cnt2 >= 5), 32'd1);

        // flush with 2 queued plus a same-cycle push
        applyReset();
        reqFlag = 3'b111;
        reqVal  = {32'h33, 32'h22, 32'h11};
        reqDest = {4'd9, 4'd8, 4'd7};
        tick();
        reqFlag = '0;
        tick();
        chk("flush_pre_flag", 32'(cdbFlag), 32'd1);
        flushIn = 1'b1; reqFlag = 3'b001; reqVal[31:0] = 32'h44;
        tick();
        chk("flush_flag", 32'(cdbFlag), 32'd0);
        chk("flush_full", 32'(reqFull), 32'd0);
        flushIn = 1'b0; reqFlag = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("flush_no_stale", 32'(cdbFlag), 32'd0);
        end

        // randomized traffic against the model
        applyReset();
        for (int c = 0; c < 400; c++) begin
            readyIn = ($urandom_range(0, 9) != 0);
            flushIn = ($urandom_range(0, 29) == 0);
            reqFlag = 3'($urandom()) & ~modelFull();
            reqVal  = {$urandom(), $urandom(), $urandom()};
            reqDest = 12'($urandom());
            tick();
        end
        idleInputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
